// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the CPU data stack. The instruction decoder imports
// the same package so both sides agree on the stack command encoding.
//   cmd_e : 3-bit stack command code carried on data_stack.cmd
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_PUSH     = 3'd1,
        CMD_POP      = 3'd2,
        CMD_POP2PUSH = 3'd3,
        CMD_DUP      = 3'd4,
        CMD_SWAP     = 3'd5,
        CMD_OVER     = 3'd6,
        CMD_RSVD     = 3'd7   // decodes as NOP
    } cmd_e;

endpackage

// File: rtl/stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// Spill storage for stack entries below TOS/NOS. Writes are synchronous and
// reads are asynchronous, so a POP can refill NOS from the RAM in the same
// cycle.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module stack_ram #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 14,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // NOTE: the array has no reset; every location is written by a PUSH before
    // any POP can read it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
// Single-cycle hardware data stack. The top two entries are held in registers
// (tos/nos); deeper entries spill to stack_ram. Commands whose preconditions
// fail are not executed and instead set a sticky overflow/underflow flag.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   cmd_valid : execute cmd this cycle
//   cmd       : stack command (stack_pkg::cmd_e)
//   din       : operand for PUSH and POP2PUSH
//   err_clr   : clears both sticky flags (a new error in the same cycle wins)
//   tos, nos  : top / next-on-stack, 0 when not present
//   depth     : current entry count
//   empty     : depth == 0
//   full      : depth == DEPTH
//   overflow  : sticky, set by a rejected growing command
//   underflow : sticky, set by a rejected shrinking command
// -----------------------------------------------------------------------------
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd,
    input  logic [WIDTH-1:0]             din,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             tos,
    output logic [WIDTH-1:0]             nos,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 2;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic             push_ok;
    logic             pop_ok;
    logic             swap_ok;
    logic             set_ovf;
    logic             set_unf;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] pop_val;
    logic             has_two;
    logic             has_three;
    logic             ram_we;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] ram_rdata;

    // Derived from registers only, so no input-to-output path exists.
    assign empty     = (depth == '0);
    assign full      = (depth == DW'(DEPTH));
    assign has_two   = (depth >= DW'(2));
    assign has_three = (depth >= DW'(3));

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        swap_ok  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        push_val = din;
        pop_val  = nos;
        // Commands are ignored while reset is held; this also blocks the RAM write.
        if (cmd_valid && !rst) begin
            case (cmd_e'(cmd))
                CMD_PUSH: begin
                    if (full) set_ovf = 1'b1;
                    else      push_ok = 1'b1;
                end
                CMD_DUP: begin
                    push_val = tos;
                    if (empty)     set_unf = 1'b1;
                    else if (full) set_ovf = 1'b1;
                    else           push_ok = 1'b1;
                end
                CMD_OVER: begin
                    // Missing operand is reported before a full stack.
                    push_val = nos;
                    if (!has_two)  set_unf = 1'b1;
                    else if (full) set_ovf = 1'b1;
                    else           push_ok = 1'b1;
                end
                CMD_POP: begin
                    if (empty) set_unf = 1'b1;
                    else       pop_ok  = 1'b1;
                end
                CMD_POP2PUSH: begin
                    pop_val = din;
                    if (!has_two) set_unf = 1'b1;
                    else          pop_ok  = 1'b1;
                end
                CMD_SWAP: begin
                    if (!has_two) set_unf = 1'b1;
                    else          swap_ok = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // On a push the old NOS becomes entry 3 at index (n+1)-3 = n-2.
    // On a pop the new NOS is the old entry 3 at index n-3.
    assign ram_we = push_ok && has_two;
    assign wr_idx = AW'(depth - DW'(2));
    assign rd_idx = has_three ? AW'(depth - DW'(3)) : '0;

    stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (nos),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values of tos/nos/depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos       <= '0;
            nos       <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tos   <= push_val;
                nos   <= tos;
                depth <= depth + DW'(1);
            end else if (pop_ok) begin
                tos   <= pop_val;
                nos   <= has_three ? ram_rdata : '0;
                depth <= depth - DW'(1);
            end else if (swap_ok) begin
                tos <= nos;
                nos <= tos;
            end
            // A new error outranks a clear in the same cycle.
            overflow  <= (overflow  && !err_clr) || set_ovf;
            underflow <= (underflow && !err_clr) || set_unf;
        end
    end

endmodule
